// File: rtl/uart_rx_data_sampler_if.sv
// Bundles the serial line, sampling controls and strobed outputs of the RX sampler.
// The master drives RX_IN/dat_samp_en/Prescale; the slave is the sampler itself.
interface uart_rx_data_sampler_if #(
    parameter int PRESCALE_W = 6
) ();
    logic                  RX_IN;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  sampled_bit;
    logic                  deser_New_bit;
    logic                  bit_tick;
    logic                  sample_glitch;

    modport master (
        output RX_IN, dat_samp_en, Prescale,
        input  sampled_bit, deser_New_bit, bit_tick, sample_glitch
    );

    modport slave (
        input  RX_IN, dat_samp_en, Prescale,
        output sampled_bit, deser_New_bit, bit_tick, sample_glitch
    );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampler: synchronise RX_IN, 3-sample mid-bit majority vote, new-bit and bit-end strobes.
// Latency: SYNC_STAGES cycles of line sync, strobe one cycle after the H-th edge; no backpressure (free-running strobes).
// Optional UART_RX_SAMPLER_GLITCH_FLAG_EN adds a registered sample-disagreement flag.
module uart_rx_data_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE_W  = 6
) (
    input  logic                          CLK,
    input  logic                          RST,
    uart_rx_data_sampler_if.slave         rx_if
);
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic                   s0_q, s0_d;
    logic                   s1_q, s1_d;
    logic                   sampled_bit_q, sampled_bit_d;
    logic                   new_bit_q, new_bit_d;
    logic                   bit_tick_q, bit_tick_d;

    logic                   rx_s;
    logic [PRESCALE_W-1:0]  p_eff;
    logic [PRESCALE_W-1:0]  half;
    logic                   en;
    logic                   at_h;
    logic                   at_wrap;
    logic                   maj;
    logic                   disagree;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign en   = rx_if.dat_samp_en;

    // Unsupported ratios fall back to 8 so the counter always has a reachable wrap point.
    always_comb begin
        p_eff = P8;
        if (rx_if.Prescale == P16 || rx_if.Prescale == P32) begin
            p_eff = rx_if.Prescale;
        end
    end

    assign half     = p_eff >> 1;
    assign at_h     = en && (edge_cnt_q == half);
    assign at_wrap  = edge_cnt_q >= (p_eff - ONE);
    assign maj      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign disagree = !((s0_q == s1_q) && (s1_q == rx_s));

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = rx_if.RX_IN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        edge_cnt_d    = '0;
        s0_d          = s0_q;
        s1_d          = s1_q;
        sampled_bit_d = sampled_bit_q;
        new_bit_d     = 1'b0;
        bit_tick_d    = 1'b0;
        if (en) begin
            edge_cnt_d = at_wrap ? '0 : edge_cnt_q + ONE;
            bit_tick_d = at_wrap;
            if (edge_cnt_q == half - TWO) begin
                s0_d = rx_s;
            end
            if (edge_cnt_q == half - ONE) begin
                s1_d = rx_s;
            end
            if (at_h) begin
                sampled_bit_d = maj;
                new_bit_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q        <= '1;
            edge_cnt_q    <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            sampled_bit_q <= 1'b1;
            new_bit_q     <= 1'b0;
            bit_tick_q    <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            edge_cnt_q    <= edge_cnt_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            sampled_bit_q <= sampled_bit_d;
            new_bit_q     <= new_bit_d;
            bit_tick_q    <= bit_tick_d;
        end
    end

    assign rx_if.sampled_bit   = sampled_bit_q;
    assign rx_if.deser_New_bit = new_bit_q;
    assign rx_if.bit_tick      = bit_tick_q;

`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
    logic glitch_q, glitch_d;

    always_comb begin
        glitch_d = 1'b0;
        if (at_h) begin
            glitch_d = disagree;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            glitch_q <= 1'b0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign rx_if.sample_glitch = glitch_q;
`else
    logic unused_disagree;
    assign unused_disagree     = disagree;
    assign rx_if.sample_glitch = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed bench for uart_rx_data_sampler: strobe timing, voting, enable/reset handling, prescale fallback.
module tb_uart_rx_data_sampler;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    logic exp_sb;

    uart_rx_data_sampler_if #(.PRESCALE_W(6)) dif ();

    uart_rx_data_sampler #(.SYNC_STAGES(2), .PRESCALE_W(6)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (dif.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
    localparam logic GLITCH_ON = 1'b1;
`else
    localparam logic GLITCH_ON = 1'b0;
`endif

    task automatic go_idle(input logic rx_level);
        dif.dat_samp_en = 1'b0;
        dif.RX_IN       = rx_level;
        repeat (4) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        dif.dat_samp_en = 1'b0;
        dif.RX_IN       = 1'b1;
        dif.Prescale    = 6'd8;
        #1;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        n_checks++;
        if (dif.sampled_bit !== 1'b1) begin n_fail++; $display("FAIL reset_sampled_bit got %b want 1", dif.sampled_bit); end
        n_checks++;
        if (dif.deser_New_bit !== 1'b0) begin n_fail++; $display("FAIL reset_new_bit got %b want 0", dif.deser_New_bit); end
        n_checks++;
        if (dif.bit_tick !== 1'b0) begin n_fail++; $display("FAIL reset_bit_tick got %b want 0", dif.bit_tick); end
        n_checks++;
        if (dif.sample_glitch !== 1'b0) begin n_fail++; $display("FAIL reset_glitch got %b want 0", dif.sample_glitch); end
        RST = 1'b1;
        exp_sb = 1'b1;
        go_idle(1'b1);
    endtask

    // RX_IN driven in iteration n is seen at edge n+2, so pattern index is n+2.
    task automatic test_p8_hold_low();
        logic [1:0] bits;
        int idx;
        bits = 2'b10;
        dif.Prescale = 6'd8;
        for (int n = -2; n < 16; n++) begin
            idx = (n + 2) / 8;
            dif.dat_samp_en = (n >= 0);
            dif.RX_IN = (idx < 2) ? bits[idx] : 1'b1;
            @(posedge CLK); #1;
            if (n >= 0) begin
                if (n % 8 == 4) exp_sb = bits[n / 8];
                n_checks++;
                if (dif.deser_New_bit !== (n % 8 == 4)) begin n_fail++; $display("FAIL p8_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n % 8 == 4)); end
                n_checks++;
                if (dif.bit_tick !== (n % 8 == 7)) begin n_fail++; $display("FAIL p8_bit_tick n=%0d got %b want %b", n, dif.bit_tick, (n % 8 == 7)); end
                n_checks++;
                if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL p8_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
                n_checks++;
                if (dif.sample_glitch !== 1'b0) begin n_fail++; $display("FAIL p8_glitch n=%0d got %b want 0", n, dif.sample_glitch); end
            end
        end
        go_idle(1'b1);
    endtask

    task automatic test_p16_frame();
        logic [9:0] frame;
        int idx;
        int strobes;
        int last;
        frame   = 10'b1_0101_0101_0;
        strobes = 0;
        last    = -1;
        dif.Prescale = 6'd16;
        for (int n = -2; n < 160; n++) begin
            idx = (n + 2) / 16;
            dif.dat_samp_en = (n >= 0);
            dif.RX_IN = (idx < 10) ? frame[idx] : 1'b1;
            @(posedge CLK); #1;
            if (n >= 0) begin
                if (n % 16 == 8) exp_sb = frame[n / 16];
                if (dif.deser_New_bit === 1'b1) begin
                    if (last >= 0) begin
                        n_checks++;
                        if (n - last !== 16) begin n_fail++; $display("FAIL p16_spacing n=%0d got %0d want 16", n, n - last); end
                    end
                    last = n;
                    strobes++;
                end
                n_checks++;
                if (dif.deser_New_bit !== (n % 16 == 8)) begin n_fail++; $display("FAIL p16_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n % 16 == 8)); end
                n_checks++;
                if (dif.bit_tick !== (n % 16 == 15)) begin n_fail++; $display("FAIL p16_bit_tick n=%0d got %b want %b", n, dif.bit_tick, (n % 16 == 15)); end
                n_checks++;
                if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL p16_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
            end
        end
        n_checks++;
        if (strobes !== 10) begin n_fail++; $display("FAIL p16_strobe_count got %0d want 10", strobes); end
        go_idle(1'b1);
    endtask

    // Bit0: one low sample at edge 3 -> 1; bit1: low at 2,3 -> 0; bit2: low at 3,4 -> 0.
    task automatic test_glitch_vote();
        logic [23:0] pat;
        logic [2:0]  vote;
        logic        exp_g;
        pat = 24'hFF_FFFF;
        pat[3]  = 1'b0;
        pat[10] = 1'b0;
        pat[11] = 1'b0;
        pat[19] = 1'b0;
        pat[20] = 1'b0;
        vote = 3'b001;
        dif.Prescale = 6'd8;
        for (int n = -2; n < 22; n++) begin
            dif.dat_samp_en = (n >= 0);
            dif.RX_IN = pat[n + 2];
            @(posedge CLK); #1;
            if (n >= 0) begin
                if (n % 8 == 4) exp_sb = vote[n / 8];
                exp_g = GLITCH_ON && (n % 8 == 4);
                n_checks++;
                if (dif.deser_New_bit !== (n % 8 == 4)) begin n_fail++; $display("FAIL glitch_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n % 8 == 4)); end
                n_checks++;
                if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL glitch_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
                n_checks++;
                if (dif.sample_glitch !== exp_g) begin n_fail++; $display("FAIL glitch_flag n=%0d got %b want %b", n, dif.sample_glitch, exp_g); end
            end
        end
        go_idle(1'b1);
    endtask

    task automatic test_enable_drop();
        dif.Prescale = 6'd32;
        for (int n = -2; n < 42; n++) begin
            dif.dat_samp_en = (n >= 0);
            dif.RX_IN = ((n + 2) / 32 == 0) ? 1'b1 : 1'b0;
            @(posedge CLK); #1;
            if (n >= 0) begin
                if (n == 16) exp_sb = 1'b1;
                n_checks++;
                if (dif.deser_New_bit !== (n == 16)) begin n_fail++; $display("FAIL drop_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n == 16)); end
                n_checks++;
                if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL drop_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
            end
        end
        // edge_cnt is now 10 in the second bit; drop enable with the line low.
        dif.dat_samp_en = 1'b0;
        dif.RX_IN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (dif.deser_New_bit !== 1'b0 || dif.bit_tick !== 1'b0) begin n_fail++; $display("FAIL drop_idle_strobe k=%0d got %b%b want 00", k, dif.deser_New_bit, dif.bit_tick); end
            n_checks++;
            if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL drop_idle_sampled k=%0d got %b want %b", k, dif.sampled_bit, exp_sb); end
        end
        for (int n = 0; n < 20; n++) begin
            dif.dat_samp_en = 1'b1;
            @(posedge CLK); #1;
            if (n == 16) exp_sb = 1'b0;
            n_checks++;
            if (dif.deser_New_bit !== (n == 16)) begin n_fail++; $display("FAIL reen_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n == 16)); end
            n_checks++;
            if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL reen_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
        end
        go_idle(1'b0);
    endtask

    task automatic test_reset_mid_bit();
        dif.Prescale = 6'd32;
        for (int n = 0; n < 15; n++) begin
            dif.dat_samp_en = 1'b1;
            dif.RX_IN = 1'b0;
            @(posedge CLK); #1;
        end
        n_checks++;
        if (dif.sampled_bit !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_sampled got %b want 0", dif.sampled_bit); end
        #2;
        RST = 1'b0;
        dif.RX_IN = 1'b1;
        #1;
        n_checks++;
        if (dif.sampled_bit !== 1'b1) begin n_fail++; $display("FAIL midrst_sampled got %b want 1", dif.sampled_bit); end
        n_checks++;
        if (dif.deser_New_bit !== 1'b0 || dif.bit_tick !== 1'b0 || dif.sample_glitch !== 1'b0) begin
            n_fail++; $display("FAIL midrst_strobes got %b%b%b want 000", dif.deser_New_bit, dif.bit_tick, dif.sample_glitch);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (dif.deser_New_bit !== 1'b0 || dif.sampled_bit !== 1'b1) begin n_fail++; $display("FAIL midrst_held got nb=%b sb=%b want nb=0 sb=1", dif.deser_New_bit, dif.sampled_bit); end
        RST = 1'b1;
        exp_sb = 1'b1;
        // Counter must restart from 0: strobe after the 17th enabled edge.
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (dif.deser_New_bit !== (n == 16)) begin n_fail++; $display("FAIL midrst_restart n=%0d got %b want %b", n, dif.deser_New_bit, (n == 16)); end
            n_checks++;
            if (dif.bit_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick n=%0d got %b want 0", n, dif.bit_tick); end
        end
        go_idle(1'b1);
    endtask

    task automatic test_illegal_prescale();
        logic [2:0] bits;
        int idx;
        bits = 3'b010;
        dif.Prescale = 6'd12;
        for (int n = -2; n < 24; n++) begin
            idx = (n + 2) / 8;
            dif.dat_samp_en = (n >= 0);
            dif.RX_IN = (idx < 3) ? bits[idx] : 1'b1;
            @(posedge CLK); #1;
            if (n >= 0) begin
                if (n % 8 == 4) exp_sb = bits[n / 8];
                n_checks++;
                if (dif.deser_New_bit !== (n % 8 == 4)) begin n_fail++; $display("FAIL p12_new_bit n=%0d got %b want %b", n, dif.deser_New_bit, (n % 8 == 4)); end
                n_checks++;
                if (dif.bit_tick !== (n % 8 == 7)) begin n_fail++; $display("FAIL p12_bit_tick n=%0d got %b want %b", n, dif.bit_tick, (n % 8 == 7)); end
                n_checks++;
                if (dif.sampled_bit !== exp_sb) begin n_fail++; $display("FAIL p12_sampled n=%0d got %b want %b", n, dif.sampled_bit, exp_sb); end
            end
        end
        go_idle(1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_sb   = 1'b1;
        test_reset();
        test_p8_hold_low();
        test_p16_frame();
        test_glitch_vote();
        test_enable_drop();
        test_reset_mid_bit();
        test_illegal_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
